// File: rtl/unit_wb_output_buffer_pkg.sv
// Shared widths and types for the unit writeback output buffer.
// Holds the id_t type and MAX_POSSIBLE_REG_BITS normally provided by cva5_types / cva5_config.
package unit_wb_output_buffer_pkg;

  localparam int unsigned MAX_POSSIBLE_REG_BITS = 32;
  localparam int unsigned ID_WIDTH              = 4;

  typedef logic [ID_WIDTH-1:0] id_t;

endpackage

// File: rtl/wb_buffer_ram.sv
// Result storage for the writeback output buffer.
// DEPTH x WIDTH array with one synchronous write port and one asynchronous read port (LUTRAM style).
module wb_buffer_ram #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 36,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/unit_wb_output_buffer.sv
// Unit-side writeback transmitter: queues completed results and offers the
// oldest one to the writeback arbiter as done/id/rd, releasing it on ack.
module unit_wb_output_buffer
  import unit_wb_output_buffer_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DATA_WIDTH = MAX_POSSIBLE_REG_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    result_valid,
  input  id_t                     result_id,
  input  logic [DATA_WIDTH-1:0]   result_data,
  output logic                    result_ready,
  output logic                    wb_done,
  output id_t                     wb_id,
  output logic [DATA_WIDTH-1:0]   wb_rd,
  input  logic                    wb_ack,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ID_W    = $bits(id_t);
  localparam int unsigned ENTRY_W = ID_W + DATA_WIDTH;

  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_push;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_wdata;
  logic [ENTRY_W-1:0] w_rdata;

  // Handshake events and flags; ready never looks at wb_ack, so a full buffer stays full through a pop cycle.
  assign result_ready = ~rst & (r_count != CNT_W'(DEPTH));
  assign wb_done      = (r_count != CNT_W'(0));
  assign w_push       = result_valid & result_ready;
  assign w_pop        = wb_done & wb_ack;
  assign occupancy    = r_count;

  assign w_wdata = {result_id, result_data};
  assign wb_id   = w_rdata[ENTRY_W-1 -: ID_W];
  assign wb_rd   = w_rdata[DATA_WIDTH-1:0];

  wb_buffer_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Protocol and sanity checks, simulation only.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(wb_ack && !wb_done))
        else $warning("unit_wb_output_buffer: wb_ack asserted while buffer empty");
      assert (r_count <= CNT_W'(DEPTH))
        else $error("unit_wb_output_buffer: count exceeds DEPTH");
    end
  end

endmodule

// File: tb/tb_unit_wb_output_buffer.sv
// Self-checking bench for unit_wb_output_buffer: directed vector table,
// hand-written corner sequences, and random traffic against a queue model.
module tb_unit_wb_output_buffer;
  import unit_wb_output_buffer_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 32;

  logic           clk;
  logic           rst;
  logic           result_valid;
  id_t            result_id;
  logic [DW-1:0]  result_data;
  logic           result_ready;
  logic           wb_done;
  id_t            wb_id;
  logic [DW-1:0]  wb_rd;
  logic           wb_ack;
  logic [2:0]     occupancy;

  int n_pass  = 0;
  int n_total = 0;

  unit_wb_output_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .result_valid (result_valid),
    .result_id    (result_id),
    .result_data  (result_data),
    .result_ready (result_ready),
    .wb_done      (wb_done),
    .wb_id        (wb_id),
    .wb_rd        (wb_rd),
    .wb_ack       (wb_ack),
    .occupancy    (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an ordered list of queued results.
  typedef struct {
    id_t           id;
    logic [DW-1:0] data;
  } ent_t;
  ent_t mq[$];

  typedef struct {
    logic          rst;
    logic          v;
    id_t           id;
    logic [DW-1:0] data;
    logic          ack;
    logic          e_done;
    id_t           e_id;
    logic [DW-1:0] e_data;
    logic [2:0]    e_occ;
    logic          e_ready;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic v, input id_t id, input logic [DW-1:0] d, input logic a);
    rst          = r;
    result_valid = v;
    result_id    = id;
    result_data  = d;
    wb_ack       = a;
  endtask

  // One clock with the currently driven inputs; the model follows the handshake rules.
  task automatic step();
    bit   push;
    bit   pop;
    ent_t e;
    ent_t tmp;
    push   = result_valid && !rst && (mq.size() < DEPTH);
    pop    = !rst && (mq.size() > 0) && wb_ack;
    e.id   = result_id;
    e.data = result_data;
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
    end else begin
      if (pop) tmp = mq.pop_front();
      if (push) mq.push_back(e);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".done"}, 64'(wb_done), 64'(mq.size() != 0));
    chk({tag, ".occ"}, 64'(occupancy), 64'(mq.size()));
    chk({tag, ".ready"}, 64'(result_ready), 64'(!rst && (mq.size() < DEPTH)));
    if (mq.size() != 0) begin
      chk({tag, ".id"}, 64'(wb_id), 64'(mq[0].id));
      chk({tag, ".rd"}, 64'(wb_rd), 64'(mq[0].data));
    end
  endtask

  task automatic addv(input logic r, input logic v, input id_t id, input logic [DW-1:0] d, input logic a,
                      input logic ed, input id_t eid, input logic [DW-1:0] edat, input logic [2:0] eocc,
                      input logic erdy);
    vec_t x;
    x.rst = r; x.v = v; x.id = id; x.data = d; x.ack = a;
    x.e_done = ed; x.e_id = eid; x.e_data = edat; x.e_occ = eocc; x.e_ready = erdy;
    vecs.push_back(x);
  endtask

  function automatic logic [DW-1:0] dat(input int k);
    return DW'(32'hA000_0000 + k * 32'h0101);
  endfunction

  initial begin
    drive(1'b1, 1'b0, '0, '0, 1'b0);

    // Single result: push, hold five cycles, ack.
    addv(1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    addv(0, 1, 3, 32'hDEADBEEF, 0,  1, 3, 32'hDEADBEEF, 1, 1);
    for (int i = 0; i < 5; i++) addv(0, 0, 0, 0, 0,  1, 3, 32'hDEADBEEF, 1, 1);
    addv(0, 0, 0, 0, 1,  0, 0, 0, 0, 1);
    // Fill to DEPTH, hold id 5 while full, pop frees a slot, drain in order.
    for (int i = 1; i <= 4; i++) addv(0, 1, id_t'(i), dat(i), 0,  1, 1, dat(1), 3'(i), (i < 4));
    addv(0, 1, 5, dat(5), 0,  1, 1, dat(1), 4, 0);
    addv(0, 1, 5, dat(5), 1,  1, 2, dat(2), 3, 1);
    addv(0, 1, 5, dat(5), 0,  1, 2, dat(2), 4, 0);
    for (int i = 3; i <= 5; i++) addv(0, 0, 0, 0, 1,  1, id_t'(i), dat(i), 3'(6 - i), 1);
    addv(0, 0, 0, 0, 1,  0, 0, 0, 0, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].v, vecs[i].id, vecs[i].data, vecs[i].ack);
      step();
      chk($sformatf("vec%0d.done", i), 64'(wb_done), 64'(vecs[i].e_done));
      chk($sformatf("vec%0d.occ", i), 64'(occupancy), 64'(vecs[i].e_occ));
      chk($sformatf("vec%0d.ready", i), 64'(result_ready), 64'(vecs[i].e_ready));
      if (vecs[i].e_done) begin
        chk($sformatf("vec%0d.id", i), 64'(wb_id), 64'(vecs[i].e_id));
        chk($sformatf("vec%0d.rd", i), 64'(wb_rd), 64'(vecs[i].e_data));
      end
    end

    // Simultaneous push and pop at occupancy 2.
    drive(0, 1, 10, dat(10), 0); step(); check_model("pp.fill0");
    drive(0, 1, 11, dat(11), 0); step(); check_model("pp.fill1");
    drive(0, 1, 12, dat(12), 1); step(); check_model("pp.both");
    chk("pp.occ_const", 64'(occupancy), 64'd2);
    chk("pp.head", 64'(wb_id), 64'd11);
    drive(0, 0, 0, 0, 1); step(); check_model("pp.drain0");
    chk("pp.tail", 64'(wb_id), 64'd12);
    drive(0, 0, 0, 0, 1); step(); check_model("pp.drain1");

    // Streaming ids 0..9 with ack every cycle: wraps pointers, no bubbles.
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, id_t'(i), dat(i), (i != 0));
      step();
      check_model($sformatf("stream%0d", i));
      chk($sformatf("stream%0d.order", i), 64'(wb_id), 64'(i));
    end
    drive(0, 0, 0, 0, 1); step(); check_model("stream.end");

    // Reset with three entries queued.
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, id_t'(13 + i), dat(13 + i), 0); step();
    end
    check_model("rst.pre");
    drive(1, 0, 0, 0, 0); step(); check_model("rst.hi");
    chk("rst.done", 64'(wb_done), 64'd0);
    chk("rst.ready", 64'(result_ready), 64'd0);
    drive(0, 0, 0, 0, 0); step(); check_model("rst.lo");
    chk("rst.ready_after", 64'(result_ready), 64'd1);
    step(); check_model("rst.nostale");

    // Ack while empty is ignored; the next push delivers normally.
    drive(0, 0, 0, 0, 1); step(); check_model("eack");
    chk("eack.occ", 64'(occupancy), 64'd0);
    drive(0, 1, 7, dat(7), 0); step(); check_model("eack.push");
    chk("eack.id", 64'(wb_id), 64'd7);
    drive(0, 0, 0, 0, 1); step(); check_model("eack.pop");

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic r, v, a;
      r = ($urandom_range(0, 49) == 0);
      v = $urandom_range(0, 99) < 60;
      a = (mq.size() != 0) && ($urandom_range(0, 99) < 50);
      drive(r, v, id_t'($urandom_range(0, 15)), DW'($urandom), a);
      step();
      check_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
